// File: rtl/exhaustive_vector_sequencer.sv
// Exhaustive vector sequencer.
// Drives every N_WIDTH-bit input vector to a DUT, in binary or Gray order.
// After SETTLE_CYC cycles it samples the DUT response, offers a
// {vector, response} record to a logger over valid/ready, and folds the
// response into a MISR signature.
// Ports:
//   CK, reset    clock and asynchronous active-high reset
//   start, mode  run request (IDLE only) and order select (0 binary, 1 Gray)
//   vec_out      vector driven to the DUT
//   dut_resp     DUT response
//   rec_valid, rec_ready, rec_vector, rec_resp   record channel to logger
//   busy, done   run in progress / sticky run-complete
//   signature    MISR state
//   vec_count    records accepted this run
module exhaustive_vector_sequencer #(
  parameter int unsigned N_WIDTH    = 3,
  parameter int unsigned OUT_WIDTH  = 1,
  parameter int unsigned SETTLE_CYC = 1,
  parameter int unsigned SIG_WIDTH  = 8,
  parameter logic [SIG_WIDTH-1:0] SIG_POLY = SIG_WIDTH'(8'h1D),
  parameter logic [SIG_WIDTH-1:0] SIG_SEED = '0
) (
  input  logic                 CK,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 mode,
  output logic [N_WIDTH-1:0]   vec_out,
  input  logic [OUT_WIDTH-1:0] dut_resp,
  output logic                 rec_valid,
  input  logic                 rec_ready,
  output logic [N_WIDTH-1:0]   rec_vector,
  output logic [OUT_WIDTH-1:0] rec_resp,
  output logic                 busy,
  output logic                 done,
  output logic [SIG_WIDTH-1:0] signature,
  output logic [N_WIDTH:0]     vec_count
);

  localparam int unsigned IDX_W = N_WIDTH + 1;
  localparam int unsigned CNT_W = $clog2(SETTLE_CYC + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = {1'b0, {N_WIDTH{1'b1}}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    EMIT   = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  mode_q, mode_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [N_WIDTH-1:0]    vec_out_q, vec_out_d;
  logic                  rec_valid_q, rec_valid_d;
  logic [N_WIDTH-1:0]    rec_vector_q, rec_vector_d;
  logic [OUT_WIDTH-1:0]  rec_resp_q, rec_resp_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [SIG_WIDTH-1:0]  sig_q, sig_d;
  logic [IDX_W-1:0]      vec_count_q, vec_count_d;

  // Vector encoding of an index: plain binary or reflected Gray.
  function automatic logic [N_WIDTH-1:0] encode(input logic [IDX_W-1:0] i,
                                                input logic m);
    logic [IDX_W-1:0] g;
    g = i ^ (i >> 1);
    return m ? g[N_WIDTH-1:0] : i[N_WIDTH-1:0];
  endfunction

  // State and output registers.
  always_ff @(posedge CK or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      mode_q       <= 1'b0;
      cnt_q        <= '0;
      vec_out_q    <= '0;
      rec_valid_q  <= 1'b0;
      rec_vector_q <= '0;
      rec_resp_q   <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      sig_q        <= SIG_SEED;
      vec_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      mode_q       <= mode_d;
      cnt_q        <= cnt_d;
      vec_out_q    <= vec_out_d;
      rec_valid_q  <= rec_valid_d;
      rec_vector_q <= rec_vector_d;
      rec_resp_q   <= rec_resp_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      sig_q        <= sig_d;
      vec_count_q  <= vec_count_d;
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    mode_d       = mode_q;
    cnt_d        = cnt_q;
    vec_out_d    = vec_out_q;
    rec_valid_d  = rec_valid_q;
    rec_vector_d = rec_vector_q;
    rec_resp_d   = rec_resp_q;
    busy_d       = busy_q;
    done_d       = done_q;
    sig_d        = sig_q;
    vec_count_d  = vec_count_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          idx_d       = '0;
          mode_d      = mode;
          sig_d       = SIG_SEED;
          vec_count_d = '0;
          done_d      = 1'b0;
          busy_d      = 1'b1;
          cnt_d       = CNT_W'(SETTLE_CYC);
          vec_out_d   = encode('0, mode);
          state_d     = SETTLE;
        end
      end
      SETTLE: begin
        cnt_d = cnt_q - CNT_W'(1);
        // Last settle cycle: the vector has been stable SETTLE_CYC cycles.
        if (cnt_q == CNT_W'(1)) begin
          rec_resp_d   = dut_resp;
          rec_vector_d = vec_out_q;
          rec_valid_d  = 1'b1;
          sig_d        = {sig_q[SIG_WIDTH-2:0], 1'b0}
                       ^ (sig_q[SIG_WIDTH-1] ? SIG_POLY : '0)
                       ^ SIG_WIDTH'(dut_resp);
          state_d      = EMIT;
        end
      end
      EMIT: begin
        if (rec_ready) begin
          rec_valid_d = 1'b0;
          vec_count_d = vec_count_q + IDX_W'(1);
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            idx_d     = idx_q + IDX_W'(1);
            vec_out_d = encode(idx_q + IDX_W'(1), mode_q);
            cnt_d     = CNT_W'(SETTLE_CYC);
            state_d   = SETTLE;
          end
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign vec_out    = vec_out_q;
  assign rec_valid  = rec_valid_q;
  assign rec_vector = rec_vector_q;
  assign rec_resp   = rec_resp_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign signature  = sig_q;
  assign vec_count  = vec_count_q;

endmodule

// File: doc/exhaustive_vector_sequencer.md
Name: exhaustive_vector_sequencer

Overview:
- Synthesizable, parametrised successor to the fixed 3-input exhaustive stimulus bench.
- Steps a DUT through every input vector of width N_WIDTH, in binary or Gray order.
- After a programmable settle time, samples the DUT response and emits a {vector, response} record over a valid/ready channel to the logger.
- Compresses all responses into a MISR signature for pass/fail comparison against a golden value.

Parameters:
- N_WIDTH, 3: DUT input vector width; run length is 2^N_WIDTH vectors (1..16).
- OUT_WIDTH, 1: DUT response width; must be <= SIG_WIDTH.
- SETTLE_CYC, 1: cycles between driving a vector and sampling the response (>= 1).
- SIG_WIDTH, 8: MISR width.
- SIG_POLY, 8'h1D: MISR feedback polynomial, taps exclude the implicit MSB.
- SIG_SEED, 0: MISR value loaded at start.

Ports:
- CK  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle run request; sampled only in IDLE.
- mode  in  1  0 = binary ascending, 1 = Gray code; latched at start.
- vec_out  out  N_WIDTH  vector driven to DUT inputs.
- dut_resp  in  OUT_WIDTH  DUT output.
- rec_valid  out  1  record available.
- rec_ready  in  1  logger accepts record.
- rec_vector  out  N_WIDTH  vector of current record.
- rec_resp  out  OUT_WIDTH  sampled response of current record.
- busy  out  1  run in progress.
- done  out  1  sticky run-complete flag.
- signature  out  SIG_WIDTH  MISR state.
- vec_count  out  N_WIDTH+1  records accepted this run.

Behaviour:
- Reset (asynchronous, any state): state = IDLE; vec_out, rec_vector, rec_resp, vec_count = 0; rec_valid, busy, done = 0; signature = SIG_SEED. A reset mid-run abandons the run; no partial record survives.
- Internal index idx (N_WIDTH+1 bits). vec_out = idx[N_WIDTH-1:0] when mode_q = 0, and idx ^ (idx >> 1) when mode_q = 1.
- IDLE:
  - On start = 1: idx = 0, mode_q = mode, signature = SIG_SEED, vec_count = 0, done = 0, busy = 1, settle counter = SETTLE_CYC, go to SETTLE.
  - vec_out becomes the encoding of 0 in the cycle after start.
- SETTLE:
  - Counter decrements each cycle; vec_out is held stable.
  - In the cycle where the counter reaches 0:
    - rec_resp <= dut_resp; rec_vector <= vec_out; rec_valid <= 1.
    - signature <= {signature[SIG_WIDTH-2:0], 1'b0} ^ (signature[SIG_WIDTH-1] ? SIG_POLY : 0) ^ zero_extend(dut_resp).
    - Go to EMIT.
  - Net effect: the response is sampled exactly SETTLE_CYC cycles after vec_out changes.
- EMIT:
  - rec_valid, rec_vector, rec_resp and vec_out are held stable until rec_valid & rec_ready.
  - rec_ready may stall indefinitely; the signature is updated once per vector, never per stall cycle.
  - On handshake: rec_valid <= 0, vec_count <= vec_count + 1.
  - If idx == 2^N_WIDTH - 1, go to DONE. Otherwise idx <= idx + 1, reload the counter, go to SETTLE.
- DONE: busy <= 0, done <= 1, go to IDLE. done stays high until the next accepted start. vec_out holds the last vector; signature holds the final value.
- start while busy is ignored. A start in the same cycle as the DONE transition is ignored; the first accepted start is in IDLE.
- Throughput with rec_ready tied high: SETTLE_CYC + 1 cycles per vector. For N_WIDTH = 3 and SETTLE_CYC = 1, a run is 16 cycles plus 1 cycle to reach done.
- The index wrap at 2^N_WIDTH never occurs; the terminal compare occurs first.

Test Plan:
1. Binary order, parity DUT:
   - Setup: N_WIDTH = 3, OUT_WIDTH = 1, SETTLE_CYC = 1, dut_resp = ^vec_out, rec_ready = 1, mode = 0, pulse start.
   - Required: records 000/0, 001/1, 010/1, 011/0, 100/1, 101/0, 110/0, 111/1.
   - Required: vec_count = 8, signature = 8'h69, done = 1 exactly 17 cycles after start, busy = 0.
2. Gray mode, same DUT:
   - Required rec_vector order: 000, 001, 011, 010, 110, 111, 101, 100.
   - Required: 8 records, done = 1.
3. Backpressure:
   - Stimulus: hold rec_ready = 0 for 5 cycles while the record for vector 011 is presented.
   - Required: rec_valid, rec_vector = 011, rec_resp and vec_out are stable throughout; signature does not change during the stall.
   - Required: final signature is still 8'h69.
4. Settle timing:
   - Setup: SETTLE_CYC = 3; DUT model delays the parity response by 2 cycles.
   - Required: all 8 records are correct (response captured 3 cycles after the vector changes).
5. Reset mid-run:
   - Stimulus: assert reset at vector 101.
   - Required: all outputs return to reset values immediately.
   - Required: a following start runs from 000 with signature reseeded to SIG_SEED.
6. Start handling:
   - Stimulus: pulse start while busy.
   - Required: run is unaffected, exactly 8 records.
   - Stimulus: pulse start after done.
   - Required: done clears, a new run begins, vec_count restarts from 0.
